// File: rtl/axi_req_arbiter_pkg.sv
// Shared state encoding, default parameters and beat-index helper for the
// instruction/data AXI request arbiter.
package axi_req_arbiter_pkg;

   localparam int INST_BEATS_DEF   = 8;
   localparam int STARVE_LIMIT_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_INST = 2'd1,
      ST_RD_DATA = 2'd2,
      ST_WRITE   = 2'd3
   } arb_state_e;

   function automatic logic [3:0] last_beat_idx(input int beats);
      return 4'(beats - 1);
   endfunction

endpackage

// File: rtl/axi_req_arbiter_if.sv
// Requester and AXI-side signal bundle of the arbiter; the arbiter takes the
// slave view, the surrounding system drives through the master view.
interface axi_req_arbiter_if;

   logic        inst_req_i;
   logic [31:0] inst_addr_i;
   logic        inst_gnt_o;
   logic        data_rreq_i;
   logic [31:0] data_raddr_i;
   logic        data_wreq_i;
   logic [31:0] data_waddr_i;
   logic [31:0] data_wdata_i;
   logic        data_wdone_o;
   logic        rvalid_inst_o;
   logic        rvalid_data_o;
   logic [31:0] rdata_o;
   logic        axi_ren_o;
   logic [31:0] axi_raddr_o;
   logic [3:0]  axi_rlen_o;
   logic        axi_rvalid_i;
   logic [31:0] axi_rdata_i;
   logic        axi_wen_o;
   logic [31:0] axi_waddr_o;
   logic [31:0] axi_wdata_o;
   logic        axi_bvalid_i;

   modport slave (
      input  inst_req_i, inst_addr_i, data_rreq_i, data_raddr_i,
             data_wreq_i, data_waddr_i, data_wdata_i,
             axi_rvalid_i, axi_rdata_i, axi_bvalid_i,
      output inst_gnt_o, data_wdone_o, rvalid_inst_o, rvalid_data_o, rdata_o,
             axi_ren_o, axi_raddr_o, axi_rlen_o,
             axi_wen_o, axi_waddr_o, axi_wdata_o
   );

   modport master (
      output inst_req_i, inst_addr_i, data_rreq_i, data_raddr_i,
             data_wreq_i, data_waddr_i, data_wdata_i,
             axi_rvalid_i, axi_rdata_i, axi_bvalid_i,
      input  inst_gnt_o, data_wdone_o, rvalid_inst_o, rvalid_data_o, rdata_o,
             axi_ren_o, axi_raddr_o, axi_rlen_o,
             axi_wen_o, axi_waddr_o, axi_wdata_o
   );

endinterface

// File: rtl/axi_req_arbiter_beat_counter.sv
// ICache refill beat counter with last-beat compare; wraps to zero on the
// final beat so every refill starts from beat 0.
module axi_req_arbiter_beat_counter
   import axi_req_arbiter_pkg::*;
#(
   parameter int BEATS = INST_BEATS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic beat_en,
   output logic beat_last
);

   localparam logic [3:0] LAST_IDX = last_beat_idx(BEATS);

   logic [3:0] count_r;

   // Beat count register, cleared when the last beat is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= 4'd0;
      end else if (beat_en) begin
         count_r <= beat_last ? 4'd0 : count_r + 4'd1;
      end
   end

   assign beat_last = (count_r == LAST_IDX);

endmodule

// File: rtl/axi_req_arbiter.sv
// Single-outstanding AXI arbiter between ICache refills and data reads/writes.
// Optional ICache starvation guard enabled by macro ARB_STARVE_GUARD_EN.
module axi_req_arbiter
   import axi_req_arbiter_pkg::*;
#(
   parameter int INST_BEATS   = INST_BEATS_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   axi_req_arbiter_if.slave  bus
);

   localparam logic [3:0] INST_RLEN = last_beat_idx(INST_BEATS);

   arb_state_e  state_r;
   arb_state_e  state_s;
   logic        grant_inst_s;
   logic        grant_rd_s;
   logic        grant_wr_s;
   logic        inst_prio_s;
   logic        beat_en_s;
   logic        beat_last_s;
   logic        inst_gnt_r;
   logic [31:0] raddr_r;
   logic [3:0]  rlen_r;
   logic [31:0] waddr_r;
   logic [31:0] wdata_r;

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);

   logic [2:0] starve_r;

   // Count data grants that bypass a waiting ICache refill; saturates at 7.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_r <= 3'd0;
      end else if (!bus.inst_req_i || grant_inst_s) begin
         starve_r <= 3'd0;
      end else if ((grant_rd_s || grant_wr_s) && (starve_r != 3'd7)) begin
         starve_r <= starve_r + 3'd1;
      end
   end

   assign inst_prio_s = (starve_r >= STARVE_LIM);
`else
   assign inst_prio_s = 1'b0;
`endif

   // IDLE arbitration: write > read > refill unless the refill has been starved.
   always_comb begin
      grant_inst_s = 1'b0;
      grant_rd_s   = 1'b0;
      grant_wr_s   = 1'b0;
      if (state_r == ST_IDLE) begin
         if (inst_prio_s && bus.inst_req_i) begin
            grant_inst_s = 1'b1;
         end else if (bus.data_wreq_i) begin
            grant_wr_s = 1'b1;
         end else if (bus.data_rreq_i) begin
            grant_rd_s = 1'b1;
         end else if (bus.inst_req_i) begin
            grant_inst_s = 1'b1;
         end else begin
            grant_inst_s = 1'b0;
         end
      end else begin
         grant_inst_s = 1'b0;
      end
   end

   assign beat_en_s = (state_r == ST_RD_INST) && bus.axi_rvalid_i;

   axi_req_arbiter_beat_counter #(
      .BEATS     (INST_BEATS)
   ) u_beat_counter (
      .clk       (clk),
      .rst       (rst),
      .beat_en   (beat_en_s),
      .beat_last (beat_last_s)
   );

   // Next-state logic; every transaction returns through IDLE for one cycle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_wr_s) begin
               state_s = ST_WRITE;
            end else if (grant_rd_s) begin
               state_s = ST_RD_DATA;
            end else if (grant_inst_s) begin
               state_s = ST_RD_INST;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RD_INST: begin
            if (beat_en_s && beat_last_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RD_INST;
            end
         end
         ST_RD_DATA: begin
            if (bus.axi_rvalid_i) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RD_DATA;
            end
         end
         ST_WRITE: begin
            if (bus.axi_bvalid_i) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WRITE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Capture request address/data at grant so requesters may change them later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_gnt_r <= 1'b0;
         raddr_r    <= 32'd0;
         rlen_r     <= 4'd0;
         waddr_r    <= 32'd0;
         wdata_r    <= 32'd0;
      end else begin
         inst_gnt_r <= grant_inst_s;
         if (grant_inst_s) begin
            raddr_r <= bus.inst_addr_i;
            rlen_r  <= INST_RLEN;
         end else if (grant_rd_s) begin
            raddr_r <= bus.data_raddr_i;
            rlen_r  <= 4'd0;
         end
         if (grant_wr_s) begin
            waddr_r <= bus.data_waddr_i;
            wdata_r <= bus.data_wdata_i;
         end
      end
   end

   assign bus.inst_gnt_o    = inst_gnt_r;
   assign bus.axi_ren_o     = (state_r == ST_RD_INST) || (state_r == ST_RD_DATA);
   assign bus.axi_wen_o     = (state_r == ST_WRITE);
   assign bus.axi_raddr_o   = raddr_r;
   assign bus.axi_rlen_o    = rlen_r;
   assign bus.axi_waddr_o   = waddr_r;
   assign bus.axi_wdata_o   = wdata_r;
   assign bus.rdata_o       = bus.axi_rdata_i;
   assign bus.rvalid_inst_o = (state_r == ST_RD_INST) && bus.axi_rvalid_i;
   assign bus.rvalid_data_o = (state_r == ST_RD_DATA) && bus.axi_rvalid_i;
   assign bus.data_wdone_o  = (state_r == ST_WRITE) && bus.axi_bvalid_i;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Self-checking bench for axi_req_arbiter: transaction table plus hand-written
// corner sequences, with a response scoreboard.
module tb_axi_req_arbiter;

   typedef enum logic [1:0] {K_INST = 2'd0, K_READ = 2'd1, K_WRITE = 2'd2} kind_e;

   typedef struct {
      kind_e       kind;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          gap;
      logic [3:0]  exp_rlen;
      int          beats;
      logic        drop_early;
   } vec_t;

   typedef struct {
      kind_e       kind;
      logic [31:0] data;
   } sb_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   sb_t  sb_q[$];

   axi_req_arbiter_if bif ();

   axi_req_arbiter #(
      .INST_BEATS   (8),
      .STARVE_LIMIT (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_req(input kind_e k, input logic v, input logic [31:0] addr,
                            input logic [31:0] wd);
      case (k)
         K_INST:  begin bif.inst_req_i  = v; bif.inst_addr_i  = addr; end
         K_READ:  begin bif.data_rreq_i = v; bif.data_raddr_i = addr; end
         default: begin bif.data_wreq_i = v; bif.data_waddr_i = addr; bif.data_wdata_i = wd; end
      endcase
   endtask

   // Waits (bounded) for the bus to go busy, then checks the granted transaction.
   task automatic wait_grant(input kind_e k, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] rlen, input string nm, output int lat);
      bit got = 1'b0;
      lat = 0;
      while (lat < 16 && !got) begin
         @(negedge clk);
         got = bif.axi_ren_o || bif.axi_wen_o;
         lat++;
      end
      chk({nm, " granted"}, 32'(got), 32'd1);
      if (got) begin
         chk({nm, " ren"}, 32'(bif.axi_ren_o), 32'(k != K_WRITE));
         chk({nm, " wen"}, 32'(bif.axi_wen_o), 32'(k == K_WRITE));
         chk({nm, " inst_gnt"}, 32'(bif.inst_gnt_o), 32'(k == K_INST));
         if (k == K_WRITE) begin
            chk({nm, " waddr"}, bif.axi_waddr_o, addr);
            chk({nm, " wdata"}, bif.axi_wdata_o, wd);
         end else begin
            chk({nm, " raddr"}, bif.axi_raddr_o, addr);
            chk({nm, " rlen"}, 32'(bif.axi_rlen_o), 32'(rlen));
         end
      end
   endtask

   // Plays the AXI slave: returns beats (or one write response), then checks idle.
   task automatic serve(input kind_e k, input int beats, input int gap, input bit keep,
                        input string nm);
      for (int b = 0; b < beats; b++) begin
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            bif.axi_rvalid_i = 1'b0;
            bif.axi_bvalid_i = 1'b0;
         end
         @(posedge clk); #1;
         if (k == K_WRITE) begin
            bif.axi_bvalid_i = 1'b1;
            sb_q.push_back('{K_WRITE, 32'h0});
         end else begin
            bif.axi_rdata_i  = $urandom;
            bif.axi_rvalid_i = 1'b1;
            sb_q.push_back('{k, bif.axi_rdata_i});
         end
         @(negedge clk);
         chk({nm, " busy"}, 32'(k == K_WRITE ? bif.axi_wen_o : bif.axi_ren_o), 32'd1);
         chk({nm, " gnt pulse"}, 32'(bif.inst_gnt_o), 32'd0);
      end
      @(posedge clk); #1;
      bif.axi_rvalid_i = 1'b0;
      bif.axi_bvalid_i = 1'b0;
      if (!keep) drive_req(k, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk({nm, " idle ren"}, 32'(bif.axi_ren_o), 32'd0);
      chk({nm, " idle wen"}, 32'(bif.axi_wen_o), 32'd0);
   endtask

   task automatic run_txn(input vec_t v, input string nm);
      int lat;
      @(posedge clk); #1;
      drive_req(v.kind, 1'b1, v.addr, v.wdata);
      wait_grant(v.kind, v.addr, v.wdata, v.exp_rlen, nm, lat);
      chk({nm, " latency"}, 32'(lat), 32'd2);
      if (v.drop_early) drive_req(v.kind, 1'b0, 32'h0, 32'h0);
      serve(v.kind, v.beats, v.gap, 1'b0, nm);
   endtask

   // Scoreboard: every flagged response must match the oldest stimulus entry.
   always @(negedge clk) begin
      if (!rst && (bif.rvalid_inst_o || bif.rvalid_data_o || bif.data_wdone_o)) begin
         sb_t   e;
         kind_e act;
         act = bif.rvalid_inst_o ? K_INST : (bif.rvalid_data_o ? K_READ : K_WRITE);
         chk("response onehot",
             32'(bif.rvalid_inst_o) + 32'(bif.rvalid_data_o) + 32'(bif.data_wdone_o), 32'd1);
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected response: got kind %0d expected none", act);
         end else begin
            e = sb_q.pop_front();
            chk("response kind", 32'(act), 32'(e.kind));
            if (e.kind != K_WRITE) chk("response data", bif.rdata_o, e.data);
         end
      end
   end

   initial begin
      vec_t        vecs[6];
      kind_e       exp_seq[6];
      bit          tail_inst;
      int          lat;
      logic [31:0] beat_d;

      vecs[0] = '{K_INST,  32'h1FC0_0000, 32'h0,         0, 4'd7, 8, 1'b0};
      vecs[1] = '{K_READ,  32'h8000_0004, 32'h0,         0, 4'd0, 1, 1'b0};
      vecs[2] = '{K_WRITE, 32'h8000_0010, 32'hDEAD_BEEF, 2, 4'd0, 1, 1'b0};
      vecs[3] = '{K_INST,  32'h0000_0040, 32'h0,         1, 4'd7, 8, 1'b1};
      vecs[4] = '{K_READ,  32'hFFFF_FFFC, 32'h0,         3, 4'd0, 1, 1'b1};
      vecs[5] = '{K_WRITE, 32'h0000_0000, 32'hFFFF_FFFF, 0, 4'd0, 1, 1'b0};

      rst = 1'b1;
      bif.inst_req_i = 1'b0;  bif.inst_addr_i  = 32'h0;
      bif.data_rreq_i = 1'b0; bif.data_raddr_i = 32'h0;
      bif.data_wreq_i = 1'b0; bif.data_waddr_i = 32'h0; bif.data_wdata_i = 32'h0;
      bif.axi_rvalid_i = 1'b0; bif.axi_bvalid_i = 1'b0;
      bif.axi_rdata_i = 32'hA5A5_5A5A;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset ren", 32'(bif.axi_ren_o), 32'd0);
      chk("reset wen", 32'(bif.axi_wen_o), 32'd0);
      chk("reset gnt", 32'(bif.inst_gnt_o), 32'd0);
      chk("reset rlen", 32'(bif.axi_rlen_o), 32'd0);
      chk("reset raddr", bif.axi_raddr_o, 32'h0);
      chk("reset rdata passthrough", bif.rdata_o, 32'hA5A5_5A5A);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Write and read raised together: write first, one IDLE cycle, then read
      @(posedge clk); #1;
      drive_req(K_WRITE, 1'b1, 32'h0000_0100, 32'h1234_5678);
      drive_req(K_READ,  1'b1, 32'h0000_0200, 32'h0);
      wait_grant(K_WRITE, 32'h0000_0100, 32'h1234_5678, 4'd0, "both wr", lat);
      serve(K_WRITE, 1, 1, 1'b0, "both wr");
      wait_grant(K_READ, 32'h0000_0200, 32'h0, 4'd0, "both rd", lat);
      chk("both rd one idle cycle", 32'(lat), 32'd1);
      serve(K_READ, 1, 0, 1'b0, "both rd");

      // Reset during beat 3 of a refill, then a full refill from beat 0
      @(posedge clk); #1;
      drive_req(K_INST, 1'b1, 32'h0000_1000, 32'h0);
      wait_grant(K_INST, 32'h0000_1000, 32'h0, 4'd7, "rst refill", lat);
      for (int b = 0; b < 2; b++) begin
         @(posedge clk); #1;
         bif.axi_rdata_i = $urandom;
         bif.axi_rvalid_i = 1'b1;
         sb_q.push_back('{K_INST, bif.axi_rdata_i});
      end
      @(posedge clk); #1;
      beat_d = $urandom;
      bif.axi_rdata_i = beat_d;
      rst = 1'b1;
      #1;
      chk("rst mid ren", 32'(bif.axi_ren_o), 32'd0);
      chk("rst mid rvalid_inst", 32'(bif.rvalid_inst_o), 32'd0);
      chk("rst mid rlen", 32'(bif.axi_rlen_o), 32'd0);
      chk("rst mid raddr", bif.axi_raddr_o, 32'h0);
      chk("rst mid rdata passthrough", bif.rdata_o, beat_d);
      drive_req(K_INST, 1'b0, 32'h0, 32'h0);
      bif.axi_rvalid_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      run_txn(vecs[0], "post rst refill");

      // Spurious responses while idle
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         bif.axi_rvalid_i = 1'b1;
         bif.axi_bvalid_i = 1'b1;
         bif.axi_rdata_i  = $urandom;
         @(negedge clk);
         chk("spurious rvalid_inst", 32'(bif.rvalid_inst_o), 32'd0);
         chk("spurious rvalid_data", 32'(bif.rvalid_data_o), 32'd0);
         chk("spurious wdone", 32'(bif.data_wdone_o), 32'd0);
         chk("spurious ren", 32'(bif.axi_ren_o), 32'd0);
      end
      @(posedge clk); #1;
      bif.axi_rvalid_i = 1'b0;
      bif.axi_bvalid_i = 1'b0;
      run_txn(vecs[1], "after spurious");

      // Refill pending while data reads stream back to back
`ifdef ARB_STARVE_GUARD_EN
      exp_seq = '{K_READ, K_READ, K_READ, K_READ, K_INST, K_READ};
      tail_inst = 1'b0;
`else
      exp_seq = '{K_READ, K_READ, K_READ, K_READ, K_READ, K_READ};
      tail_inst = 1'b1;
`endif
      @(posedge clk); #1;
      drive_req(K_INST, 1'b1, 32'h0000_2000, 32'h0);
      drive_req(K_READ, 1'b1, 32'h0000_3000, 32'h0);
      for (int i = 0; i < 6; i++) begin
         wait_grant(exp_seq[i], (exp_seq[i] == K_INST) ? 32'h0000_2000 : 32'h0000_3000, 32'h0,
                    (exp_seq[i] == K_INST) ? 4'd7 : 4'd0, $sformatf("stream%0d", i), lat);
         chk($sformatf("stream%0d latency", i), 32'(lat), (i == 0) ? 32'd2 : 32'd1);
         serve(exp_seq[i], (exp_seq[i] == K_INST) ? 8 : 1, 0,
               (exp_seq[i] == K_READ) && (i < 5), $sformatf("stream%0d", i));
      end
      if (tail_inst) begin
         wait_grant(K_INST, 32'h0000_2000, 32'h0, 4'd7, "stream tail", lat);
         serve(K_INST, 8, 0, 1'b0, "stream tail");
      end

      repeat (2) @(negedge clk);
      chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
